// File: rtl/truth_table_pkg.sv
// Shared constants and state encoding for the truth-table sweeper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package truth_table_pkg;

   localparam int N_INPUTS              = 3;
   localparam int N_ROWS                = 8;
   localparam int DEFAULT_SETTLE_CYCLES = 4;
   localparam int CNT_W                 = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Down-counter that times how long each input row is held before sampling.
// Latency: zero flag reflects the registered count; load/decrement take effect next edge.
// Backpressure: none; load wins over decrement when both are requested.
module settle_timer
   import truth_table_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: reload, count down (saturating at zero), or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 8 rows of a 3-input circuit, samples its output, compares with an expected code.
// Latency: row k sampled SETTLE_CYCLES*(k+1) edges after start; done one cycle after last sample.
// Backpressure: none; start ignored while busy, abort cancels a sweep at the next edge.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [N_ROWS-1:0]   expected,
   input  logic                dut_out,
   output logic [N_INPUTS-1:0] drive,
   output logic                busy,
   output logic                done,
   output logic [N_ROWS-1:0]   table_code,
   output logic                pass,
   output logic [N_ROWS-1:0]   mismatch_mask
);

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_SETTLE = 2'(ST_SETTLE);
   localparam logic [1:0] S_DONE   = 2'(ST_DONE);

   localparam logic [CNT_W-1:0]    RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [N_INPUTS-1:0] LAST_ROW = N_INPUTS'(N_ROWS - 1);

   logic [1:0]          state_q,  state_d;
   logic [N_INPUTS-1:0] row_q,    row_d;
   logic [N_ROWS-1:0]   shadow_q, shadow_d;
   logic [N_ROWS-1:0]   exp_q,    exp_d;
   logic [N_ROWS-1:0]   code_q,   code_d;
   logic [N_ROWS-1:0]   mask_q,   mask_d;
   logic                pass_q,   pass_d;

   logic tmr_load;
   logic tmr_dec;
   logic tmr_zero;

   settle_timer u_settle_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (RELOAD),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Sweep sequencing: accept start, capture one row per settle period, publish results only on completion.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      shadow_d = shadow_q;
      exp_d    = exp_q;
      code_d   = code_q;
      mask_d   = mask_q;
      pass_d   = pass_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d  = S_SETTLE;
               row_d    = '0;
               shadow_d = '0;
               exp_d    = expected;
               tmr_load = 1'b1;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               // Abort outranks a capture due on the same edge; results stay untouched.
               state_d = S_IDLE;
               row_d   = '0;
            end else if (tmr_zero) begin
               shadow_d[row_q] = dut_out;
               if (row_q == LAST_ROW) begin
                  state_d = S_DONE;
                  row_d   = '0;
                  code_d  = shadow_d;
                  mask_d  = shadow_d ^ exp_q;
                  pass_d  = (shadow_d == exp_q);
               end else begin
                  row_d    = row_q + 1'b1;
                  tmr_load = 1'b1;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            row_d   = '0;
         end
      endcase
   end

   // State and result registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         shadow_q <= '0;
         exp_q    <= '0;
         code_q   <= '0;
         mask_q   <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         shadow_q <= shadow_d;
         exp_q    <= exp_d;
         code_q   <= code_d;
         mask_q   <= mask_d;
         pass_q   <= pass_d;
      end
   end

   // row_q is forced to zero whenever the FSM leaves SETTLE, so it can drive the circuit directly.
   assign drive         = row_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign table_code    = code_q;
   assign pass          = pass_q;
   assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

   localparam int S_MAIN = 4;
   localparam int S_ALT  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] expected = 8'h00;
   logic       dut_out;
   logic [2:0] drive;
   logic       busy, done, pass;
   logic [7:0] table_code, mismatch_mask;

   logic       start2 = 1'b0;
   logic [7:0] expected2 = 8'h00;
   logic       dut_out2;
   logic [2:0] drive2;
   logic       busy2, done2, pass2;
   logic [7:0] table_code2, mismatch_mask2;

   logic       dly_mode = 1'b0;
   logic [2:0] p1 = 3'd0, p2 = 3'd0, p3 = 3'd0;
   logic [2:0] q1 = 3'd0, q2 = 3'd0, q3 = 3'd0;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int hold2 [8];
   int cyc;

   always #5 clk = ~clk;

   truth_table_sweeper #(.SETTLE_CYCLES(S_MAIN)) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .expected(expected),
      .dut_out(dut_out), .drive(drive), .busy(busy), .done(done),
      .table_code(table_code), .pass(pass), .mismatch_mask(mismatch_mask)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(S_ALT)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .expected(expected2),
      .dut_out(dut_out2), .drive(drive2), .busy(busy2), .done(done2),
      .table_code(table_code2), .pass(pass2), .mismatch_mask(mismatch_mask2)
   );

   // Circuit under test: out = in1 ^ in2, either immediate or seen through a 3-cycle delay line.
   always @(posedge clk) begin
      p1 <= drive;  p2 <= p1; p3 <= p2;
      q1 <= drive2; q2 <= q1; q3 <= q2;
   end
   assign dut_out  = dly_mode ? (p3[2] ^ p3[1]) : (drive[2] ^ drive[1]);
   assign dut_out2 = q3[2] ^ q3[1];

   // Truth of in1^in2 for row number r.
   function automatic logic f_row(input int r);
      return ((r >> 2) & 1) != ((r >> 1) & 1);
   endfunction

   // Code the sweeper must recover: row k is sampled (k+1)*s cycles after start;
   // the circuit answers for whatever row was applied d cycles before that sample.
   function automatic logic [7:0] predict(input int s, input int d);
      logic [7:0] r;
      int j;
      r = 8'h00;
      for (int k = 0; k < 8; k++) begin
         j = (k + 1) * s - 1 - d;
         r[k] = f_row((j < 0) ? 0 : (j / s));
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model in terms of elapsed cycles since start acceptance.
   int         m_phase = 0;   // 0 idle, 1 sweeping, 2 done cycle
   int         m_n = 0;       // edges since start acceptance
   logic [7:0] m_exp = 8'h00, m_pred = 8'h00, m_tc = 8'h00, m_mask = 8'h00;
   logic       m_pass = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = 0; m_n = 0; m_exp = 8'h00; m_tc = 8'h00; m_mask = 8'h00; m_pass = 1'b0;
      end else begin
         case (m_phase)
            0: if (start && !abort) begin
               m_phase = 1; m_n = 0; m_exp = expected;
               m_pred = predict(S_MAIN, dly_mode ? 3 : 0);
            end
            1: if (abort) begin
               m_phase = 0;
            end else begin
               m_n++;
               if (m_n == 8 * S_MAIN) begin
                  m_phase = 2;
                  m_tc = m_pred;
                  m_mask = m_pred ^ m_exp;
                  m_pass = (m_pred == m_exp);
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   // Cycle-by-cycle comparison of the main instance against the model.
   always @(negedge clk) begin
      chk("drive", 32'(drive), (m_phase == 1) ? 32'(m_n / S_MAIN) : 32'd0);
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("table_code", 32'(table_code), 32'(m_tc));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("mismatch_mask", 32'(mismatch_mask), 32'(m_mask));
      if (done) done_cnt++;
      if (busy2 && !done2) hold2[drive2]++;
   end

   task automatic wait_done(input int which, input int limit, output int cycles);
      cycles = 0;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if ((which == 0) ? done : done2) return;
      end
      total++;
      bad++;
      $display("FAIL wait_done(%0d): no done within %0d cycles", which, limit);
   endtask

   task automatic pulse_start(input logic [7:0] e);
      @(negedge clk); #1 start = 1'b1; expected = e;
      @(negedge clk); #1 start = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 8; k++) hold2[k] = 0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_code", 32'(table_code), 32'h00);
      chk("reset_busy", 32'(busy), 32'h0);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);

      // Model self-pins.
      chk("pred_comb_s4", 32'(predict(4, 0)), 32'h3C);
      chk("pred_dly_s4", 32'(predict(4, 3)), 32'h3C);
      chk("pred_dly_s2", 32'(predict(2, 3)), 32'h78);

      // XOR circuit, matching expectation; done lands 32 edges after acceptance.
      done_cnt = 0;
      pulse_start(8'h3C);
      wait_done(0, 100, cyc);
      chk("done_latency", 32'(cyc), 32'd32);
      chk("A_code", 32'(table_code), 32'h3C);
      chk("A_pass", 32'(pass), 32'h1);
      chk("A_mask", 32'(mismatch_mask), 32'h00);

      // Same circuit, one expected bit off.
      pulse_start(8'h3D);
      wait_done(0, 100, cyc);
      chk("B_code", 32'(table_code), 32'h3C);
      chk("B_pass", 32'(pass), 32'h0);
      chk("B_mask", 32'(mismatch_mask), 32'h01);

      // Delayed circuit: settle 4 recovers it, settle 2 does not.
      dly_mode = 1'b1;
      for (int k = 0; k < 8; k++) hold2[k] = 0;
      @(negedge clk); #1 start = 1'b1; expected = 8'h3C; start2 = 1'b1; expected2 = 8'h3C;
      @(negedge clk); #1 start = 1'b0; start2 = 1'b0;
      wait_done(1, 100, cyc);
      chk("C2_code", 32'(table_code2), 32'h78);
      chk("C2_pass", 32'(pass2), 32'h0);
      chk("C2_mask", 32'(mismatch_mask2), 32'h44);
      for (int k = 0; k < 8; k++) chk($sformatf("C2_hold_row%0d", k), 32'(hold2[k]), 32'd2);
      wait_done(0, 100, cyc);
      chk("C_code", 32'(table_code), 32'h3C);
      chk("C_pass", 32'(pass), 32'h1);
      dly_mode = 1'b0;
      @(negedge clk);

      // Abort while row 5 is applied.
      done_cnt = 0;
      pulse_start(8'h00);
      for (int i = 0; i < 100 && drive != 3'd5; i++) @(negedge clk);
      chk("D_reached_row5", 32'(drive), 32'd5);
      #1 abort = 1'b1;
      @(negedge clk); #1 abort = 1'b0;
      chk("D_busy", 32'(busy), 32'h0);
      chk("D_drive", 32'(drive), 32'h0);
      chk("D_code", 32'(table_code), 32'h3C);
      repeat (3) @(negedge clk);
      chk("D_no_done", 32'(done_cnt), 32'd0);

      // start and abort together in idle: nothing starts.
      #1 start = 1'b1; abort = 1'b1;
      @(negedge clk); #1 start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'(busy), 32'h0);

      // Reset between edges mid-sweep.
      pulse_start(8'h3C);
      repeat (10) @(negedge clk);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("E_rst_busy", 32'(busy), 32'h0);
      chk("E_rst_drive", 32'(drive), 32'h0);
      chk("E_rst_code", 32'(table_code), 32'h00);
      chk("E_rst_pass", 32'(pass), 32'h0);
      chk("E_rst_mask", 32'(mismatch_mask), 32'h00);
      chk("E_rst_done", 32'(done), 32'h0);
      @(negedge clk); #1 reset = 1'b0;
      @(negedge clk);

      // Fresh sweep after reset with start pulses while busy.
      done_cnt = 0;
      pulse_start(8'h3C);
      repeat (5) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      repeat (8) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      wait_done(0, 100, cyc);
      repeat (4) @(negedge clk);
      chk("E_code", 32'(table_code), 32'h3C);
      chk("E_single_done", 32'(done_cnt), 32'd1);
      chk("E_idle_after", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, meaning clock cycles each input row is held before dut_out is sampled (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a sweep; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1, cancels a sweep in progress.
REQ-006 The block SHALL have port expected, input, 8, expected truth-table code; latched on start acceptance.
REQ-007 The block SHALL have port dut_out, input, 1, output of the 3-input logic circuit under test.
REQ-008 The block SHALL have port drive, output, 3, the {in1,in2,in3} row applied to the circuit under test.
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking sweep completion.
REQ-011 The block SHALL have port table_code, output, 8, recovered truth table; bit k = dut_out sampled with drive == k.
REQ-012 The block SHALL have ports pass (output, 1) and mismatch_mask (output, 8): table_code == expected_latched, and table_code XOR expected_latched.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, DONE.
REQ-014 In IDLE with start=1 at edge E0: SHALL latch expected, set row index 0, drive=0, load settle counter with SETTLE_CYCLES-1, enter SETTLE.
REQ-015 In SETTLE the counter SHALL decrement every edge; at an edge where it equals 0, dut_out SHALL be captured into shadow bit [index].
REQ-016 On that capture edge, if index < 7: index and drive SHALL increment and counter reload; if index == 7: enter DONE.
REQ-017 Row k SHALL therefore be sampled at edge E0 + (k+1)*SETTLE_CYCLES; drive SHALL be stable for exactly SETTLE_CYCLES cycles per row.
REQ-018 On entering DONE, table_code SHALL load the complete shadow register and pass/mismatch_mask update from it; done=1 for exactly the one cycle in DONE, then IDLE.
REQ-019 table_code, pass, mismatch_mask SHALL hold their values until the next completed sweep; a partial sweep SHALL never alter them.
REQ-020 abort=1 in SETTLE SHALL return to IDLE at the next edge, drive=0, no done pulse; abort has priority over capture on the same edge.
REQ-021 start while busy SHALL be ignored; start and abort both high in IDLE: abort wins, no sweep starts.
REQ-022 drive SHALL be 0 in IDLE and DONE.
REQ-023 With SETTLE_CYCLES=1 a capture SHALL occur every edge (sweep 8 cycles plus DONE).

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, drive=0, busy=0, done=0, table_code=0x00, mismatch_mask=0x00, pass=0, shadow/expected_latched=0, counter=0.
REQ-025 Reset mid-sweep SHALL discard the sweep with no done pulse; first start after release behaves as REQ-014.

Structure
REQ-026 Package truth_table_pkg SHALL hold the state enum, N_INPUTS=3, N_ROWS=8, and default SETTLE_CYCLES.
REQ-027 The settle counter SHALL be one sub-module, settle_timer (load, decrement, zero flag); all else in truth_table_sweeper.

Verification
REQ-028 Model 0x3C (out = in1 XOR in2), expected=0x3C, SETTLE_CYCLES=4, start pulse -> done at cycle after edge E0+32, table_code=0x3C, pass=1, mismatch_mask=0x00.
REQ-029 Same model, expected=0x3D -> table_code=0x3C, pass=0, mismatch_mask=0x01.
REQ-030 Model with 3-cycle output delay, SETTLE_CYCLES=2 vs 4 -> 2 gives wrong code, 4 gives 0x3C; drive held exactly SETTLE_CYCLES cycles per row.
REQ-031 abort at row 5 after a prior 0x3C result -> IDLE next edge, drive=0, no done, table_code still 0x3C.
REQ-032 reset asserted between clock edges mid-sweep -> outputs zero immediately; start pulses while busy ignored (single done per sweep).
